pipe_exec_controller: RTL
=========================

Name: pipe_exec_controller

Overview:
Sequences execution of the 5-stage MIPS pipeline under debug-unit command: free RUN, single STEP, automatic drain on HALT, then park.
Merges the load-use stall request from the hazard detection unit into the final PC, IF/ID and ID-bubble controls.
Sits between the debug/UART command unit and the pipeline register enables.
Keeps a count of executed (enabled) clock cycles for readback.

Parameters:
DRAIN_CYCLES, 4, cycles pipeline stays enabled after HALT leaves ID (HALT reaches WB); must be >=1
CNT_W, 32, width of executed-cycle counter

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-high reset
I_CMD_VALID  input  1  command strobe from debug unit
I_CMD  input  2  00 NOP, 01 RUN, 10 STEP, 11 ABORT
O_CMD_READY  output  1  controller accepts RUN/STEP this cycle
I_HZ_STALL  input  1  load-use stall request from hazard detection
I_HALT_ID  input  1  instruction in ID is HALT
O_PIPE_EN  output  1  global enable for all pipeline registers and register file/memory writes
O_PC_WRITE  output  1  PC update enable
O_IFID_WRITE  output  1  IF/ID register write enable
O_ID_BUBBLE  output  1  force control signals entering ID/EX to zero (NOP)
O_DONE  output  1  one-cycle pulse: STEP finished or drain finished
O_HALTED  output  1  level: program halted, pipeline parked
O_CYCLE_CNT  output  CNT_W  number of cycles with O_PIPE_EN=1

Behaviour:
- States: IDLE, RUN, STEP, DRAIN, HALTED. Encoding is free.
- Reset (async): state IDLE, drain counter 0, O_CYCLE_CNT 0, O_DONE 0, O_HALTED 0.
- RESET mid-operation aborts immediately, whatever the state.
- Outputs are decoded combinationally from state plus I_HZ_STALL/I_HALT_ID. O_DONE and O_HALTED are registered.
- O_PIPE_EN=1 in RUN, STEP, DRAIN; 0 in IDLE, HALTED. When O_PIPE_EN=0: PC_WRITE=IFID_WRITE=ID_BUBBLE=0.
- RUN/STEP gating, stall priority over HALT:
  - I_HZ_STALL=1: PC_WRITE=0, IFID_WRITE=0, ID_BUBBLE=1. HALT not acted on this cycle.
  - else I_HALT_ID=1: PC_WRITE=0, IFID_WRITE=0, ID_BUBBLE=0 (HALT advances to EX). Next state DRAIN, drain counter loaded with DRAIN_CYCLES.
  - else PC_WRITE=1, IFID_WRITE=1, ID_BUBBLE=0.
- DRAIN: PC_WRITE=0, IFID_WRITE=0, ID_BUBBLE=1. Counter decrements each cycle; on the cycle it reads 1, next state HALTED, O_DONE pulses the following cycle, O_HALTED sets.
- IDLE: O_CMD_READY=1. Valid RUN goes to RUN; valid STEP goes to STEP. NOP and ABORT stay in IDLE.
- STEP lasts exactly one enabled cycle, then IDLE with an O_DONE pulse the next cycle. If HALT is taken during STEP, go to DRAIN instead (no STEP done pulse; DRAIN's pulse only).
- RUN stays in RUN until HALT is taken or ABORT. RUN/STEP commands received in RUN are ignored.
- HALTED: O_CMD_READY=0. RUN/STEP ignored.
- O_CMD_READY=1 only in IDLE. RUN/STEP are accepted only when ready.
- ABORT (valid & 11) is accepted in any state, has priority over everything but RESET, and acts next edge:
  - state IDLE, drain counter 0, O_HALTED 0, O_CYCLE_CNT 0.
  - no O_DONE pulse.
  - O_PIPE_EN=0 in the ABORT cycle itself.
- O_CYCLE_CNT increments on every cycle with O_PIPE_EN=1, saturates at all-ones (no wrap).

Optional Feature:
Macro PIPE_BREAKPOINT_EN.
- Defined: adds ports I_BP_VALID (1), I_BP_ADDR (32), I_PC (32), O_BP_HIT (1).
  - In RUN, when I_BP_VALID=1, I_PC==I_BP_ADDR and there is no stall and no HALT, that cycle runs normally, then the state goes to IDLE.
  - O_BP_HIT and O_DONE pulse together the next cycle.
  - STEP ignores breakpoints.
- Undefined: ports absent, RUN stops only on HALT or ABORT.

Test Plan:
- Reset mid-RUN -> all outputs 0 except O_CMD_READY=1 within same cycle; O_CYCLE_CNT=0.
- STEP x3 with no stall/halt -> each gives exactly one O_PIPE_EN=1 cycle with PC_WRITE=1, O_DONE pulse 1 cycle later; O_CYCLE_CNT=3.
- RUN, I_HZ_STALL=1 and I_HALT_ID=1 same cycle, then halt alone next cycle -> first cycle ID_BUBBLE=1, state RUN; second cycle enters DRAIN; 4 DRAIN cycles with ID_BUBBLE=1, PC_WRITE=0; then O_DONE pulse, O_HALTED=1, O_PIPE_EN=0.
- In HALTED issue RUN then ABORT -> RUN ignored (O_PIPE_EN stays 0); after ABORT: IDLE, O_HALTED=0, O_CYCLE_CNT=0, O_CMD_READY=1.
- CNT_W=4, RUN 20 cycles without halt -> O_CYCLE_CNT saturates at 15.
- PIPE_BREAKPOINT_EN, RUN with I_BP_ADDR=0x10, I_PC reaching 0x10 at cycle 5 -> O_BP_HIT and O_DONE pulse at cycle 6, state IDLE, O_CYCLE_CNT=5.

Source files
------------

// File: rtl/pipe_exec_controller.sv
// pipe_exec_controller
// Sequences the 5-stage pipeline under debug-unit command (RUN, STEP, ABORT),
// drains the pipeline after a HALT leaves ID, then parks it. Merges the
// load-use stall request into the PC / IF-ID / ID-bubble controls and counts
// enabled clock cycles.
//
// Ports:
//   CLK, RESET        clock (rising edge), asynchronous active-high reset
//   I_CMD_VALID/I_CMD debug command strobe and opcode (NOP/RUN/STEP/ABORT)
//   O_CMD_READY       RUN/STEP accepted this cycle (IDLE only)
//   I_HZ_STALL        load-use stall request from hazard detection
//   I_HALT_ID         HALT instruction sits in ID
//   O_PIPE_EN         global pipeline/regfile/memory write enable
//   O_PC_WRITE        PC update enable
//   O_IFID_WRITE      IF/ID register write enable
//   O_ID_BUBBLE       zero the control signals entering ID/EX
//   O_DONE            registered one-cycle pulse: STEP or drain finished
//   O_HALTED          registered level: program halted, pipeline parked
//   O_CYCLE_CNT       saturating count of cycles with O_PIPE_EN=1
//
// Optional build macro PIPE_BREAKPOINT_EN adds I_BP_VALID, I_BP_ADDR, I_PC and
// O_BP_HIT: RUN returns to IDLE after executing the cycle whose PC matches.
module pipe_exec_controller #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_CMD_VALID,
  input  logic [1:0]       I_CMD,
  output logic             O_CMD_READY,
  input  logic             I_HZ_STALL,
  input  logic             I_HALT_ID,
  output logic             O_PIPE_EN,
  output logic             O_PC_WRITE,
  output logic             O_IFID_WRITE,
  output logic             O_ID_BUBBLE,
  output logic             O_DONE,
  output logic             O_HALTED,
  output logic [CNT_W-1:0] O_CYCLE_CNT
`ifdef PIPE_BREAKPOINT_EN
  ,
  input  logic             I_BP_VALID,
  input  logic [31:0]      I_BP_ADDR,
  input  logic [31:0]      I_PC,
  output logic             O_BP_HIT
`endif
);

  localparam int unsigned DRN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] CMD_RUN   = 2'b01;
  localparam logic [1:0] CMD_STEP  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e             state_q, state_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               done_q, done_d;
  logic               halted_q, halted_d;
  logic               bp_hit_q, bp_hit_d;

  logic               abort_c;
  logic               run_cmd_c;
  logic               step_cmd_c;
  logic               bp_match_c;
  logic               pipe_en_c;
  logic               pc_write_c;
  logic               ifid_write_c;
  logic               id_bubble_c;
  logic               cmd_ready_c;

  assign abort_c    = I_CMD_VALID && (I_CMD == CMD_ABORT);
  assign run_cmd_c  = I_CMD_VALID && (I_CMD == CMD_RUN);
  assign step_cmd_c = I_CMD_VALID && (I_CMD == CMD_STEP);

`ifdef PIPE_BREAKPOINT_EN
  assign bp_match_c = I_BP_VALID && (I_PC == I_BP_ADDR);
`else
  assign bp_match_c = 1'b0;
`endif

  // State register and registered status outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      drain_q     <= '0;
      cycle_cnt_q <= '0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
      bp_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cycle_cnt_q <= cycle_cnt_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
      bp_hit_q    <= bp_hit_d;
    end
  end

  // Next-state and pipeline control decode
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    cycle_cnt_d  = cycle_cnt_q;
    done_d       = 1'b0;
    halted_d     = halted_q;
    bp_hit_d     = 1'b0;
    pipe_en_c    = 1'b0;
    pc_write_c   = 1'b0;
    ifid_write_c = 1'b0;
    id_bubble_c  = 1'b0;
    cmd_ready_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready_c = 1'b1;
        if (run_cmd_c) begin
          state_d = ST_RUN;
        end else if (step_cmd_c) begin
          state_d = ST_STEP;
        end
      end

      ST_RUN, ST_STEP: begin
        pipe_en_c = 1'b1;
        if (I_HZ_STALL) begin
          // Stall wins over HALT; HALT is re-evaluated once the stall clears
          id_bubble_c = 1'b1;
          if (state_q == ST_STEP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else if (I_HALT_ID) begin
          // HALT advances into EX; the pipeline then drains behind it
          state_d = ST_DRAIN;
          drain_d = DRN_W'(DRAIN_CYCLES);
        end else begin
          pc_write_c   = 1'b1;
          ifid_write_c = 1'b1;
          if (state_q == ST_STEP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (bp_match_c) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            bp_hit_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        pipe_en_c   = 1'b1;
        id_bubble_c = 1'b1;
        drain_d     = drain_q - DRN_W'(1);
        if (drain_q <= DRN_W'(1)) begin
          state_d  = ST_HALTED;
          done_d   = 1'b1;
          halted_d = 1'b1;
        end
      end

      ST_HALTED: begin
        state_d = ST_HALTED;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Saturating executed-cycle counter
    if (pipe_en_c && (cycle_cnt_q != {CNT_W{1'b1}})) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end

    // ABORT overrides everything and freezes the pipeline this very cycle
    if (abort_c) begin
      state_d      = ST_IDLE;
      drain_d      = '0;
      cycle_cnt_d  = '0;
      done_d       = 1'b0;
      halted_d     = 1'b0;
      bp_hit_d     = 1'b0;
      pipe_en_c    = 1'b0;
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      id_bubble_c  = 1'b0;
    end
  end

  assign O_CMD_READY  = cmd_ready_c;
  assign O_PIPE_EN    = pipe_en_c;
  assign O_PC_WRITE   = pc_write_c;
  assign O_IFID_WRITE = ifid_write_c;
  assign O_ID_BUBBLE  = id_bubble_c;
  assign O_DONE       = done_q;
  assign O_HALTED     = halted_q;
  assign O_CYCLE_CNT  = cycle_cnt_q;

`ifdef PIPE_BREAKPOINT_EN
  assign O_BP_HIT = bp_hit_q;
`else
  logic unused_bp_hit;
  assign unused_bp_hit = bp_hit_q;
`endif

endmodule
